// File: rtl/memcore_pkg.sv
`default_nettype none
// ============================================================================
// Package  : memcore_pkg
// Purpose  : Shared defaults, FSM encodings and lane helper for the row ctrl.
// Revision : 1.0
// ============================================================================
package memcore_pkg;

    localparam int c_DEF_DW    = 32;
    localparam int c_DEF_WORDS = 64;
    localparam int c_DEF_ROWS  = 256;

    typedef logic [2:0] state_t;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FILL  = 3'd1;
    localparam logic [2:0] c_ST_WRITE = 3'd2;
    localparam logic [2:0] c_ST_READ  = 3'd3;
    localparam logic [2:0] c_ST_RWAIT = 3'd4;
    localparam logic [2:0] c_ST_DRAIN = 3'd5;

    // Lane i of a flattened row lives at bits [DW*i +: DW].
    function automatic logic [c_DEF_DW-1:0] laneOf(
        input logic [c_DEF_DW*c_DEF_WORDS-1:0] row,
        input logic [$clog2(c_DEF_WORDS)-1:0]  idx
    );
        logic [c_DEF_WORDS-1:0][c_DEF_DW-1:0] lanes;
        lanes = row;
        return lanes[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/memcore_row_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : memcore_row_ctrl_if
// Purpose   : Host command/word handshakes plus the MemCore_v1 row port.
// Revision  : 1.0
// ============================================================================
interface memcore_row_ctrl_if
    import memcore_pkg::*;
#(
    parameter int DW    = c_DEF_DW,
    parameter int WORDS = c_DEF_WORDS,
    parameter int ROWS  = c_DEF_ROWS
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_we;
    logic [$clog2(ROWS)-1:0]  cmd_row;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [DW-1:0]            wr_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [DW-1:0]            rd_data;
    logic                     busy;
    logic [ROWS-1:0]          mem_row_en;
    logic                     mem_we;
    logic                     mem_re;
    logic [DW*WORDS-1:0]      mem_wdata;
    logic [DW*WORDS-1:0]      mem_rdata;

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_we, cmd_row, wr_valid, wr_data, rd_ready, mem_rdata,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy,
               mem_row_en, mem_we, mem_re, mem_wdata
    );

    // Host plus memory-array side.
    modport master (
        output cmd_valid, cmd_we, cmd_row, wr_valid, wr_data, rd_ready, mem_rdata,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy,
               mem_row_en, mem_we, mem_re, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/memcore_row_buffer.sv
`default_nettype none
// ============================================================================
// Module   : memcore_row_buffer
// Purpose  : Row register with per-lane write, full-row load and lane read mux.
// Revision : 1.0
// ============================================================================
module memcore_row_buffer
    import memcore_pkg::*;
#(
    parameter int DW    = c_DEF_DW,
    parameter int WORDS = c_DEF_WORDS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wrEn,
    input  logic [$clog2(WORDS)-1:0]   i_wrIdx,
    input  logic [DW-1:0]              i_wrData,
    input  logic                       i_loadEn,
    input  logic [DW*WORDS-1:0]        i_loadData,
    input  logic [$clog2(WORDS)-1:0]   i_rdIdx,
    output logic [DW-1:0]              o_rdData,
    output logic [DW*WORDS-1:0]        o_row
);
    logic [WORDS-1:0][DW-1:0] r_lanes;

    // A full-row load wins over a lane write; the FSM never requests both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lanes <= '0;
        end else if (i_loadEn) begin
            r_lanes <= i_loadData;
        end else if (i_wrEn) begin
            r_lanes[i_wrIdx] <= i_wrData;
        end
    end

    assign o_rdData = r_lanes[i_rdIdx];
    assign o_row    = r_lanes;

endmodule
`default_nettype wire

// File: rtl/memcore_row_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : memcore_row_ctrl
// Purpose  : Word-serial host transfers to single-cycle MemCore_v1 row ops.
// Revision : 1.0
// ============================================================================
module memcore_row_ctrl
    import memcore_pkg::*;
#(
    parameter int DW     = c_DEF_DW,
    parameter int WORDS  = c_DEF_WORDS,
    parameter int ROWS   = c_DEF_ROWS,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    memcore_row_ctrl_if.slave bus
);
    localparam int c_CNT_W = $clog2(WORDS);
    localparam int c_ROW_W = $clog2(ROWS);
    localparam int c_LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(WORDS - 1);
    localparam logic [c_LAT_W-1:0] c_LAT_INIT = c_LAT_W'(RD_LAT);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);

    logic [2:0]          r_state;
    logic [c_CNT_W-1:0]  r_wordCnt;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_LAT_W-1:0]  r_latCnt;

    logic                w_lastWord;
    logic                w_fillBeat;
    logic                w_drainBeat;
    logic                w_capture;
    logic [ROWS-1:0]     w_rowEn;
    logic [DW-1:0]       w_rdLane;
    logic [DW*WORDS-1:0] w_rowBuf;

    assign w_lastWord  = (r_wordCnt == c_LAST);
    assign w_fillBeat  = (r_state == c_ST_FILL)  && bus.wr_valid;
    assign w_drainBeat = (r_state == c_ST_DRAIN) && bus.rd_ready;
    // Capture on the edge where the countdown steps from 1 to 0 (RD_LAT >= 1).
    assign w_capture   = (r_state == c_ST_RWAIT) && (r_latCnt == c_LAT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_wordCnt <= '0;
            r_row     <= '0;
            r_latCnt  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_row     <= bus.cmd_row;
                        r_wordCnt <= '0;
                        r_state   <= bus.cmd_we ? c_ST_FILL : c_ST_READ;
                    end
                end
                c_ST_FILL: begin
                    if (bus.wr_valid) begin
                        r_wordCnt <= r_wordCnt + 1'b1;
                        if (w_lastWord) r_state <= c_ST_WRITE;
                    end
                end
                c_ST_WRITE: r_state <= c_ST_IDLE;
                c_ST_READ: begin
                    r_latCnt <= c_LAT_INIT;
                    r_state  <= c_ST_RWAIT;
                end
                c_ST_RWAIT: begin
                    r_latCnt <= r_latCnt - 1'b1;
                    if (w_capture) begin
                        r_wordCnt <= '0;
                        r_state   <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (bus.rd_ready) begin
                        r_wordCnt <= r_wordCnt + 1'b1;
                        if (w_lastWord) r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rowEn = '0;
        if ((r_state == c_ST_WRITE) || (r_state == c_ST_READ)) begin
            w_rowEn[r_row] = 1'b1;
        end
    end

    memcore_row_buffer #(
        .DW    (DW),
        .WORDS (WORDS)
    ) u_rowBuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wrEn     (w_fillBeat),
        .i_wrIdx    (r_wordCnt),
        .i_wrData   (bus.wr_data),
        .i_loadEn   (w_capture),
        .i_loadData (bus.mem_rdata),
        .i_rdIdx    (r_wordCnt),
        .o_rdData   (w_rdLane),
        .o_row      (w_rowBuf)
    );

    assign bus.cmd_ready  = (r_state == c_ST_IDLE);
    assign bus.busy       = (r_state != c_ST_IDLE);
    assign bus.wr_ready   = (r_state == c_ST_FILL);
    assign bus.rd_valid   = (r_state == c_ST_DRAIN);
    assign bus.rd_data    = w_rdLane;
    assign bus.mem_we     = (r_state == c_ST_WRITE);
    assign bus.mem_re     = (r_state == c_ST_READ);
    assign bus.mem_row_en = w_rowEn;
    assign bus.mem_wdata  = w_rowBuf;

    // Drain handshake is only meaningful in DRAIN; kept for clarity of intent.
    logic w_unusedDrain;
    assign w_unusedDrain = w_drainBeat;

endmodule
`default_nettype wire

// File: tb/tb_memcore_row_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_memcore_row_ctrl
// Purpose  : Self-checking bench for memcore_row_ctrl with a MemCore_v1 model.
// Revision : 1.0
// ============================================================================
module tb_memcore_row_ctrl;
    import memcore_pkg::*;

    localparam int c_DW    = 32;
    localparam int c_WORDS = 64;
    localparam int c_ROWS  = 256;

    typedef struct {
        bit          we;
        logic [7:0]  row;
        logic [31:0] base;
        bit          gap;
        logic [3:0]  pat;
    } vec_t;

    logic clk;
    logic rst_n;

    memcore_row_ctrl_if #(.DW(c_DW), .WORDS(c_WORDS), .ROWS(c_ROWS)) bus();

    memcore_row_ctrl #(
        .DW(c_DW), .WORDS(c_WORDS), .ROWS(c_ROWS), .RD_LAT(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int weCount = 0;
    int reCount = 0;

    logic [c_DW*c_WORDS-1:0] memModel [c_ROWS];
    logic [31:0]             expMem   [c_ROWS][c_WORDS];
    logic [31:0]             wrWords  [c_WORDS];
    logic [31:0]             sbq [$];
    vec_t                    vecs [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int onehotIdx(input logic [c_ROWS-1:0] v);
        for (int i = 0; i < c_ROWS; i++) if (v[i]) return i;
        return 0;
    endfunction

    // MemCore_v1 stand-in: one-edge read latency, row write on WE.
    always @(posedge clk) begin
        if (bus.mem_we || bus.mem_re)
            chk("row_onehot", 256'($countones(bus.mem_row_en)), 256'd1);
        if (bus.mem_we) begin
            weCount <= weCount + 1;
            memModel[onehotIdx(bus.mem_row_en)] <= bus.mem_wdata;
        end
        if (bus.mem_re) begin
            reCount <= reCount + 1;
            bus.mem_rdata <= memModel[onehotIdx(bus.mem_row_en)];
        end
    end

    task automatic fillWords(input logic [31:0] base);
        for (int i = 0; i < c_WORDS; i++) wrWords[i] = base + 32'(i);
    endtask

    task automatic doWrite(input logic [7:0] row, input bit gap, input int beats);
        int we0;
        we0 = weCount;
        chk("wr_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_row = row;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("wr_ready_next", bus.wr_ready, 1);
        for (int i = 0; i < beats; i++) begin
            if (gap && (i % 9 == 4)) begin
                bus.wr_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = wrWords[i];
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        if (beats < c_WORDS) return;
        chk("wr_mem_we", bus.mem_we, 1);
        chk("wr_row_en", bus.mem_row_en, 256'(1) << row);
        chk("wr_lane12", laneOf(bus.mem_wdata, 6'd12), wrWords[12]);
        chk("wr_lane60", laneOf(bus.mem_wdata, 6'd60), wrWords[60]);
        @(posedge clk); #1;
        chk("wr_we_off", {bus.mem_we, |bus.mem_row_en}, 0);
        chk("wr_cmd_ready_n2", bus.cmd_ready, 1);
        chk("wr_we_pulses", weCount - we0, 1);
        for (int i = 0; i < c_WORDS; i++) expMem[row][i] = wrWords[i];
    endtask

    task automatic doRead(input logic [7:0] row, input logic [3:0] pat);
        int k, beats, re0;
        logic [31:0] held, e;
        bit stalled;
        re0 = reCount;
        chk("rd_cmd_ready", bus.cmd_ready, 1);
        for (int i = 0; i < c_WORDS; i++) sbq.push_back(expMem[row][i]);
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_row = row;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("rd_mem_re", bus.mem_re, 1);
        chk("rd_row_en", bus.mem_row_en, 256'(1) << row);
        @(posedge clk); #1;
        chk("rd_rwait_quiet", {bus.mem_re, |bus.mem_row_en, bus.rd_valid}, 0);
        @(posedge clk); #1;
        chk("rd_first_beat_c3", bus.rd_valid, 1);
        k = 0; beats = 0; stalled = 0; held = '0;
        while (sbq.size() > 0 && k < 400) begin
            bus.rd_ready = pat[2'(k)];
            if (stalled) chk("rd_hold", bus.rd_data, held);
            stalled = 0;
            if (bus.rd_valid) begin
                if (bus.rd_ready) begin
                    e = sbq.pop_front();
                    chk("rd_beat", bus.rd_data, e);
                    beats++;
                end else begin
                    held = bus.rd_data;
                    stalled = 1;
                end
            end
            @(posedge clk); #1;
            k++;
        end
        bus.rd_ready = 1'b0;
        chk("rd_beats", beats, c_WORDS);
        chk("rd_back_idle", {bus.rd_valid, bus.cmd_ready}, 2'b01);
        chk("rd_re_pulses", reCount - re0, 1);
        sbq.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int we0;
        vecs[0] = '{1'b1, 8'd0,   32'h1000_0000, 1'b0, 4'b1111};
        vecs[1] = '{1'b0, 8'd1,   32'h0,         1'b0, 4'b1111};
        vecs[2] = '{1'b1, 8'd255, 32'hC0DE_0000, 1'b1, 4'b1111};
        vecs[3] = '{1'b0, 8'd255, 32'h0,         1'b0, 4'b1001};
        vecs[4] = '{1'b0, 8'd0,   32'h0,         1'b0, 4'b1001};
        vecs[5] = '{1'b1, 8'd128, 32'h5555_0000, 1'b1, 4'b1111};
        vecs[6] = '{1'b0, 8'd128, 32'h0,         1'b0, 4'b1011};

        for (int r = 0; r < c_ROWS; r++) begin
            memModel[r] = '0;
            for (int i = 0; i < c_WORDS; i++) expMem[r][i] = '0;
        end
        for (int i = 0; i < c_WORDS; i++) begin
            expMem[1][i] = 32'hA500_0000 + 32'(i);
            memModel[1][i*c_DW +: c_DW] = 32'hA500_0000 + 32'(i);
        end

        bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_row = '0;
        bus.wr_valid = 0; bus.wr_data = '0; bus.rd_ready = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_flags", {bus.busy, bus.wr_ready, bus.rd_valid, bus.mem_we, bus.mem_re}, 0);
        chk("rst_row_en", bus.mem_row_en, 0);
        chk("rst_wdata", |bus.mem_wdata, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].we) begin
                fillWords(vecs[v].base);
                doWrite(vecs[v].row, vecs[v].gap, c_WORDS);
            end else begin
                doRead(vecs[v].row, vecs[v].pat);
            end
        end

        // Reset in the middle of a fill: partial row must vanish, no WE.
        we0 = weCount;
        fillWords(32'hDEAD_0000);
        doWrite(8'd2, 1'b0, 30);
        chk("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_idle", {bus.cmd_ready, bus.busy, bus.wr_ready}, 3'b100);
        chk("mid_rst_wdata", |bus.mem_wdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_no_we", weCount - we0, 0);
        fillWords(32'h2222_0000);
        doWrite(8'd2, 1'b0, c_WORDS);
        doRead(8'd2, 4'b1111);

        // Round trip through the array model with distinctive lanes.
        fillWords(32'h0707_0000);
        wrWords[1]  = 32'h1234_5678;
        wrWords[60] = 32'h1122_3344;
        doWrite(8'd1, 1'b0, c_WORDS);
        doRead(8'd1, 4'b1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
